// File: rtl/idecode_regfile_pkg.sv
// -----------------------------------------------------------------------------
// idecode_regfile_pkg
// Shared CPU definitions for the decode stage: the I-type opcodes whose
// immediate is zero-extended and the architectural register indices that the
// register file and decode mux treat specially.
// -----------------------------------------------------------------------------
package idecode_regfile_pkg;

    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_SLTIU = 6'h0B;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned XLEN     = 32;

    // Logical immediates and sltiu treat the 16-bit field as unsigned.
    function automatic logic is_zero_ext_op(input logic [5:0] opcode);
        return (opcode == OP_ANDI) || (opcode == OP_ORI) ||
               (opcode == OP_XORI) || (opcode == OP_SLTIU);
    endfunction

    // Widen the 16-bit immediate field to a full operand.
    function automatic logic [XLEN-1:0] extend_imm(input logic [15:0] imm,
                                                   input logic        zero_ext);
        logic fill;
        fill = zero_ext ? 1'b0 : imm[15];
        return {{16{fill}}, imm};
    endfunction

endpackage

// File: rtl/idecode_regfile_regfile32.sv
// -----------------------------------------------------------------------------
// regfile32
// 32 x 32-bit register file with two combinational read ports and one
// synchronous write port.
//
// Ports:
//   clock      - rising-edge clock for all state
//   reset      - synchronous active-low reset; clears every register except
//                $29, which loads RESET_SP. Wins over a simultaneous write.
//   rd_addr_1  - read port 1 address
//   rd_addr_2  - read port 2 address
//   rd_data_1  - read port 1 data (old value during a same-cycle write)
//   rd_data_2  - read port 2 data
//   wr_en      - write enable, committed on the rising edge
//   wr_addr    - write address; writes to $0 are dropped
//   wr_data    - write data
// -----------------------------------------------------------------------------
module regfile32
    import idecode_regfile_pkg::*;
#(
    parameter logic [31:0] RESET_SP = 32'h0000_7FFC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rd_addr_1,
    input  logic [4:0]  rd_addr_2,
    output logic [31:0] rd_data_1,
    output logic [31:0] rd_data_2,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [NUM_REGS];

    // $0 keeps a storage slot so the array indexes cleanly with a 5-bit
    // address; it is reset to 0, never written, and masked on read anyway.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == int'(REG_SP)) ? RESET_SP : 32'h0000_0000;
            end
        end else if (wr_en && (wr_addr != REG_ZERO)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write-to-read bypass: a read in the write cycle sees the old value.
    always_comb begin
        rd_data_1 = 32'h0000_0000;
        rd_data_2 = 32'h0000_0000;
        if (rd_addr_1 != REG_ZERO) begin
            rd_data_1 = regs[rd_addr_1];
        end
        if (rd_addr_2 != REG_ZERO) begin
            rd_data_2 = regs[rd_addr_2];
        end
    end

endmodule

// File: rtl/idecode_regfile.sv
// -----------------------------------------------------------------------------
// idecode_regfile
// Instruction decode stage: register operand reads, write-back address/data
// selection and 16-bit immediate extension.
//
// Ports:
//   clock        - rising-edge clock
//   reset        - synchronous active-low reset ($29 <= RESET_SP, rest <= 0)
//   Instruction  - current instruction from fetch
//   link_addr    - PC+4 from fetch, written to $31 on Jal
//   ALU_result   - execute-stage result for write-back
//   read_data    - memory/IO load data for write-back
//   RegWrite     - write-back enable
//   RegDst       - 1: write rd (Instruction[15:11]), 0: write rt
//   MemtoReg     - 1: write read_data, 0: write ALU_result
//   Jal          - link write of link_addr to $31, overrides the above
//   Read_data_1  - rs operand (combinational)
//   Read_data_2  - rt operand (combinational)
//   Sign_extend  - extended immediate (combinational from Instruction)
// -----------------------------------------------------------------------------
module idecode_regfile
    import idecode_regfile_pkg::*;
#(
    parameter logic [31:0] RESET_SP = 32'h0000_7FFC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic [31:0] link_addr,
    input  logic [31:0] ALU_result,
    input  logic [31:0] read_data,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic        MemtoReg,
    input  logic        Jal,
    output logic [31:0] Read_data_1,
    output logic [31:0] Read_data_2,
    output logic [31:0] Sign_extend
);

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    assign opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign rd     = Instruction[15:11];
    assign imm    = Instruction[15:0];

    // Jal forces the link write regardless of RegWrite/RegDst/MemtoReg.
    // Gating with reset keeps the enable low in a reset cycle; the register
    // file also gives reset priority, so this is belt and braces.
    always_comb begin
        wr_en   = (RegWrite | Jal) & reset;
        wr_addr = rt;
        wr_data = ALU_result;
        if (Jal) begin
            wr_addr = REG_RA;
            wr_data = link_addr;
        end else begin
            if (RegDst) begin
                wr_addr = rd;
            end
            if (MemtoReg) begin
                wr_data = read_data;
            end
        end
    end

    assign Sign_extend = extend_imm(imm, is_zero_ext_op(opcode));

    regfile32 #(
        .RESET_SP (RESET_SP)
    ) u_regfile32 (
        .clock     (clock),
        .reset     (reset),
        .rd_addr_1 (rs),
        .rd_addr_2 (rt),
        .rd_data_1 (Read_data_1),
        .rd_data_2 (Read_data_2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

endmodule
